// File: rtl/tmds_video_scheduler.sv
// Raster timing generator and pixel scheduler feeding the red/green/blue TMDS encoders.
// It locks the upstream pixel stream to the frame origin and recovers from underflow or SOF misalignment.
module tmds_video_scheduler #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int HS_POL   = 0,
   parameter int VS_POL   = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic [23:0] pix_data,
   input  logic        pix_valid,
   input  logic        pix_sof,
   output logic        pix_ready,
   output logic [7:0]  enc_r,
   output logic [7:0]  enc_g,
   output logic [7:0]  enc_b,
   output logic        enc_de,
   output logic [1:0]  enc_ctrl_b,
   output logic [1:0]  enc_ctrl_g,
   output logic [1:0]  enc_ctrl_r,
   output logic        frame_start,
   output logic        underflow,
   output logic        sync_err,
   input  logic        err_clr
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);
   localparam logic       HS_IDLE   = (HS_POL == 0);
   localparam logic       VS_IDLE   = (VS_POL == 0);
   localparam logic [1:0] CTRL_IDLE = {VS_IDLE, HS_IDLE};

   typedef enum logic [1:0] {
      IDLE,
      WAIT_SOF,
      RUN
   } state_t;

   state_t          state_q, state_d;
   logic [HW-1:0]   hc_q, hc_d;
   logic [VW-1:0]   vc_q, vc_d;
   logic [23:0]     pix_q, pix_d;
   logic            de_q, de_d;
   logic [1:0]      ctrl_q, ctrl_d;
   logic            fs_q, fs_d;
   logic            uf_q, uf_d;
   logic            se_q, se_d;
   logic            uf_set, se_set;

   logic            active, origin, hs_raw, vs_raw, h_last, v_last;
   logic [1:0]      sync_ctrl;

   assign active    = (hc_q < HW'(H_ACTIVE)) && (vc_q < VW'(V_ACTIVE));
   assign origin    = (hc_q == '0) && (vc_q == '0);
   assign hs_raw    = (hc_q >= HW'(H_ACTIVE + H_FP)) && (hc_q < HW'(H_ACTIVE + H_FP + H_SYNC));
   assign vs_raw    = (vc_q >= VW'(V_ACTIVE + V_FP)) && (vc_q < VW'(V_ACTIVE + V_FP + V_SYNC));
   assign h_last    = (hc_q == HW'(H_TOTAL - 1));
   assign v_last    = (vc_q == VW'(V_TOTAL - 1));
   assign sync_ctrl = {vs_raw ^ VS_IDLE, hs_raw ^ HS_IDLE};

   // The raster free-runs in every non-idle state; the source never stalls it.
   always_comb begin
      hc_d = hc_q;
      vc_d = vc_q;
      if (state_q != IDLE) begin
         if (h_last) begin
            hc_d = '0;
            vc_d = v_last ? '0 : vc_q + 1'b1;
         end else begin
            hc_d = hc_q + 1'b1;
         end
      end
      if (!enable) begin
         hc_d = '0;
         vc_d = '0;
      end
   end

   always_comb begin
      state_d   = state_q;
      pix_ready = 1'b0;
      pix_d     = '0;
      de_d      = 1'b0;
      ctrl_d    = CTRL_IDLE;
      fs_d      = 1'b0;
      uf_set    = 1'b0;
      se_set    = 1'b0;
      unique case (state_q)
         IDLE: begin
            state_d = WAIT_SOF;
         end
         WAIT_SOF: begin
            pix_ready = pix_valid & (~pix_sof | origin);
            ctrl_d    = sync_ctrl;
            de_d      = active;
            if (origin && pix_valid && pix_sof) begin
               pix_d   = pix_data;
               fs_d    = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            pix_ready = active;
            ctrl_d    = sync_ctrl;
            fs_d      = origin;
            if (active) begin
               de_d = 1'b1;
               if (pix_valid) begin
                  pix_d = pix_data;
                  if (pix_sof != origin) begin
                     se_set  = 1'b1;
                     state_d = WAIT_SOF;
                  end
               end else begin
                  uf_set  = 1'b1;
                  state_d = WAIT_SOF;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (!enable) begin
         state_d   = IDLE;
         pix_ready = 1'b0;
         pix_d     = '0;
         de_d      = 1'b0;
         ctrl_d    = CTRL_IDLE;
         fs_d      = 1'b0;
         uf_set    = 1'b0;
         se_set    = 1'b0;
      end
      // A same-cycle error event overrides err_clr.
      uf_d = (uf_q & ~err_clr) | uf_set;
      se_d = (se_q & ~err_clr) | se_set;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         hc_q    <= '0;
         vc_q    <= '0;
         pix_q   <= '0;
         de_q    <= 1'b0;
         ctrl_q  <= CTRL_IDLE;
         fs_q    <= 1'b0;
         uf_q    <= 1'b0;
         se_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         hc_q    <= hc_d;
         vc_q    <= vc_d;
         pix_q   <= pix_d;
         de_q    <= de_d;
         ctrl_q  <= ctrl_d;
         fs_q    <= fs_d;
         uf_q    <= uf_d;
         se_q    <= se_d;
      end
   end

   assign enc_r       = pix_q[23:16];
   assign enc_g       = pix_q[15:8];
   assign enc_b       = pix_q[7:0];
   assign enc_de      = de_q;
   assign enc_ctrl_b  = ctrl_q;
   assign enc_ctrl_g  = 2'b00;
   assign enc_ctrl_r  = 2'b00;
   assign frame_start = fs_q;
   assign underflow   = uf_q;
   assign sync_err    = se_q;

endmodule

// File: tb/tb_tmds_video_scheduler.sv
// Randomized self-checking bench for tmds_video_scheduler on a tiny 8x6 raster, plus
// a line-timing measurement on a default 640x480 instance.
module tb_tmds_video_scheduler;

   localparam int HA = 4, HF = 1, HS = 2, HB = 1;
   localparam int VA = 3, VF = 1, VS = 1, VB = 1;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int FRAME = HT * VT;
   localparam int PIX_PER_FRAME = HA * VA;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic [23:0] pixData = '0;
   logic        pixValid = 1'b0;
   logic        pixSof = 1'b0;
   logic        errClr = 1'b0;
   logic        pixReady;
   logic [7:0]  encR, encG, encB;
   logic        encDe;
   logic [1:0]  encCtrlB, encCtrlG, encCtrlR;
   logic        frameStart, underflow, syncErr;

   logic        bigEnable = 1'b0;
   logic        bigReady;
   logic [7:0]  bigR, bigG, bigB;
   logic        bigDe;
   logic [1:0]  bigCtrlB, bigCtrlG, bigCtrlR;
   logic        bigFs, bigUf, bigSe;

   always #5 clk = ~clk;

   tmds_video_scheduler #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .HS_POL(0), .VS_POL(0)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable),
      .pix_data(pixData), .pix_valid(pixValid), .pix_sof(pixSof), .pix_ready(pixReady),
      .enc_r(encR), .enc_g(encG), .enc_b(encB), .enc_de(encDe),
      .enc_ctrl_b(encCtrlB), .enc_ctrl_g(encCtrlG), .enc_ctrl_r(encCtrlR),
      .frame_start(frameStart), .underflow(underflow), .sync_err(syncErr), .err_clr(errClr)
   );

   tmds_video_scheduler bigDut (
      .clk(clk), .rst_n(rst_n), .enable(bigEnable),
      .pix_data(24'h0), .pix_valid(1'b0), .pix_sof(1'b0), .pix_ready(bigReady),
      .enc_r(bigR), .enc_g(bigG), .enc_b(bigB), .enc_de(bigDe),
      .enc_ctrl_b(bigCtrlB), .enc_ctrl_g(bigCtrlG), .enc_ctrl_r(bigCtrlR),
      .frame_start(bigFs), .underflow(bigUf), .sync_err(bigSe), .err_clr(1'b0)
   );

   int checkCount = 0;
   int errorCount = 0;

   // Every comparison funnels through here so the summary counts stay honest.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Reference model: raster position is a cycle index within the frame, lock is a single flag.
   bit          mRun, mLock, mUf, mSe;
   int          mT;
   logic [23:0] expRgb;
   bit          expDe, expFs, expReady;
   logic [1:0]  expCtrlB;

   task automatic modelReset();
      mRun = 0; mLock = 0; mUf = 0; mSe = 0; mT = 0;
   endtask

   task automatic modelStep(input bit en, input bit v, input bit s, input logic [23:0] d, input bit clr);
      int  h, ln;
      bit  act, org, hsOn, vsOn, ufSet, seSet;
      ufSet = 0; seSet = 0;
      expRgb = '0; expDe = 0; expFs = 0; expCtrlB = 2'b11; expReady = 0;
      if (!mRun || !en) begin
         mRun  = !mRun && en;
         mLock = 0;
         mT    = 0;
      end else begin
         h    = mT % HT;
         ln   = mT / HT;
         act  = (h < HA) && (ln < VA);
         org  = (mT == 0);
         hsOn = (h >= HA + HF) && (h < HA + HF + HS);
         vsOn = (ln >= VA + VF) && (ln < VA + VF + VS);
         expCtrlB = {!vsOn, !hsOn};
         if (!mLock) begin
            expReady = v && (!s || org);
            expDe    = act;
            if (org && v && s) begin
               expRgb = d; expFs = 1; mLock = 1;
            end
         end else begin
            expReady = act;
            expFs    = org;
            if (act) begin
               expDe = 1;
               if (v) begin
                  expRgb = d;
                  if (org != s) begin seSet = 1; mLock = 0; end
               end else begin
                  ufSet = 1; mLock = 0;
               end
            end
         end
         mT = (mT + 1) % FRAME;
      end
      mUf = (mUf && !clr) || ufSet;
      mSe = (mSe && !clr) || seSet;
   endtask

   // Stream source: beats numbered from 0, every PIX_PER_FRAME-th beat carries SOF.
   int unsigned srcIdx = 0;
   logic [23:0] beatData = 24'h000001;
   bit          countMode = 1;

   task automatic nextBeat();
      srcIdx++;
      beatData = countMode ? 24'(srcIdx + 1) : 24'($urandom);
   endtask

   task automatic checkIdle(input string tag);
      checkOutput({tag, "_rgb"}, {8'h0, encR, encG, encB}, 32'h0);
      checkOutput({tag, "_de"}, encDe, 1'b0);
      checkOutput({tag, "_ctrl_b"}, encCtrlB, 2'b11);
      checkOutput({tag, "_ctrl_gr"}, {encCtrlG, encCtrlR}, 4'h0);
      checkOutput({tag, "_fs"}, frameStart, 1'b0);
      checkOutput({tag, "_uf"}, underflow, 1'b0);
      checkOutput({tag, "_se"}, syncErr, 1'b0);
      checkOutput({tag, "_ready"}, pixReady, 1'b0);
   endtask

   // One clock: drive inputs at posedge+1, check pix_ready, then check registered outputs.
   task automatic applyStimulus(input bit en, input bit dropValid, input bit forceSof, input bit clr);
      enable   = en;
      pixValid = !dropValid;
      pixData  = beatData;
      pixSof   = ((srcIdx % PIX_PER_FRAME) == 0) || forceSof;
      errClr   = clr;
      #1;
      modelStep(en, pixValid, pixSof, pixData, clr);
      checkOutput("pix_ready", pixReady, expReady);
      @(posedge clk);
      #1;
      if (pixValid && expReady) nextBeat();
      checkOutput("enc_rgb", {8'h0, encR, encG, encB}, {8'h0, expRgb});
      checkOutput("enc_de", encDe, expDe);
      checkOutput("enc_ctrl_b", encCtrlB, expCtrlB);
      checkOutput("enc_ctrl_gr", {encCtrlG, encCtrlR}, 4'h0);
      checkOutput("frame_start", frameStart, expFs);
      checkOutput("underflow", underflow, mUf);
      checkOutput("sync_err", syncErr, mSe);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bit done;
      int guard;
      int deRise, deRise2, hsFall, hsFall2, deCount, hsLow;
      bit prevDe, prevHs, vsHigh;

      modelReset();
      repeat (2) @(posedge clk);
      #1;
      checkIdle("reset");
      rst_n = 1'b1;

      // Clean stream with counting pixel values, three frames.
      for (int i = 0; i < 3 * FRAME + 2; i++) applyStimulus(1, 0, 0, 0);

      // Single missing beat at (2,1), then relock on the next frame.
      done = 0;
      for (int i = 0; i < 2 * FRAME; i++) begin
         if (!done && mLock && mT == HT + 2) begin
            applyStimulus(1, 1, 0, 0);
            done = 1;
         end else begin
            applyStimulus(1, 0, 0, 0);
         end
      end
      checkOutput("uf_seen", done, 1'b1);

      // SOF on pixel 3 of line 0, relock, then clear the stickies.
      done = 0;
      for (int i = 0; i < 2 * FRAME; i++) begin
         if (!done && mLock && mT == 3) begin
            applyStimulus(1, 0, 1, 0);
            done = 1;
         end else begin
            applyStimulus(1, 0, 0, 0);
         end
      end
      checkOutput("se_seen", done, 1'b1);
      applyStimulus(1, 0, 0, 1);
      applyStimulus(1, 0, 0, 0);

      // Enable dropped for one clock mid-line while locked.
      done = 0;
      for (int i = 0; i < 3 * FRAME; i++) begin
         if (!done && mLock && mT == 2 * HT + 1) begin
            applyStimulus(0, 0, 0, 0);
            done = 1;
         end else begin
            applyStimulus(1, 0, 0, 0);
         end
      end
      checkOutput("en_toggle_seen", done, 1'b1);

      // Random data, drops, stray SOFs, clears and enable glitches.
      countMode = 0;
      for (int i = 0; i < 1500; i++) begin
         applyStimulus($urandom_range(0, 299) != 0, $urandom_range(0, 29) == 0,
                       $urandom_range(0, 59) == 0, $urandom_range(0, 49) == 0);
      end

      // Asynchronous reset asserted while the raster sits at hc=2.
      guard = 0;
      while (!(mRun && (mT % HT) == 2) && guard < 100) begin
         applyStimulus(1, 0, 0, 0);
         guard++;
      end
      checkOutput("async_wait", guard < 100, 1'b1);
      pixValid = 1'b1;
      #1;
      rst_n = 1'b0;
      #1;
      checkIdle("async_rst");
      @(posedge clk);
      #1;
      checkIdle("rst_hold");
      rst_n = 1'b1;
      modelReset();
      for (int i = 0; i < 3 * FRAME; i++) applyStimulus(1, 0, 0, 0);

      // Default 640x480 instance: measure one line of DE and hsync.
      bigEnable = 1'b1;
      deRise = -1; deRise2 = -1; hsFall = -1; hsFall2 = -1;
      deCount = 0; hsLow = 0; prevDe = 0; prevHs = 1; vsHigh = 1;
      for (int c = 0; c < 1800; c++) begin
         @(posedge clk);
         #1;
         if (bigDe && !prevDe) begin
            if (deRise < 0) deRise = c;
            else if (deRise2 < 0) deRise2 = c;
         end
         if (deRise >= 0 && deRise2 < 0 && bigDe) deCount++;
         if (!bigCtrlB[0] && prevHs) begin
            if (hsFall < 0) hsFall = c;
            else if (hsFall2 < 0) hsFall2 = c;
         end
         if (hsFall >= 0 && hsFall2 < 0 && !bigCtrlB[0]) hsLow++;
         if (!bigCtrlB[1]) vsHigh = 0;
         prevDe = bigDe;
         prevHs = bigCtrlB[0];
      end
      checkOutput("big_line_period", deRise2 - deRise, 800);
      checkOutput("big_de_width", deCount, 640);
      checkOutput("big_hs_start", hsFall - deRise, 656);
      checkOutput("big_hs_width", hsLow, 96);
      checkOutput("big_hs_period", hsFall2 - hsFall, 800);
      checkOutput("big_vs_inactive", vsHigh, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
